// File: rtl/rv32_dmem_responder_if.sv
// rtl/rv32_dmem_responder_if.sv - valid/ready request and response bus between an RV32 core and its data memory
interface rv32_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32_dmem_responder.sv
// rtl/rv32_dmem_responder.sv - multi-cycle RV32 data-memory responder with byte lanes and fault decode
// Define MISALIGNED_SPLIT_EN to split misaligned half/word accesses into two word accesses.
module rv32_dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 8192,
  parameter int          WAIT_CYCLES = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  rv32_dmem_responder_if.slave dmem
);

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam int          IW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {IDLE, WAIT, ACC0, ACC1, RSP} state_t;

  state_t        state_q;
  logic          req_ready_q, rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic [1:0]    rsp_err_q;
  logic [3:0]    wait_cnt_q;
  logic          we_q, uns_q;
  logic [1:0]    size_q, off_q, err_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q, asm_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [2:0]    req_nbytes;
  logic [32:0]   req_last;
  logic [1:0]    req_err;
  logic          req_misaligned;

  // Error priority: illegal size, then access fault, then misalignment.
  always_comb begin
    case (dmem.req_size)
      2'd0:    req_nbytes = 3'd1;
      2'd1:    req_nbytes = 3'd2;
      2'd2:    req_nbytes = 3'd4;
      default: req_nbytes = 3'd0;
    endcase
    req_last       = {1'b0, dmem.req_addr} + 33'(req_nbytes) - 33'd1;
    req_misaligned = (dmem.req_size == 2'd1 && dmem.req_addr[0]) ||
                     (dmem.req_size == 2'd2 && dmem.req_addr[1:0] != 2'd0);
    req_err = 2'd0;
    if (dmem.req_size == 2'd3)
      req_err = 2'd3;
    else if ({1'b0, dmem.req_addr} < {1'b0, ADDR_BASE} || req_last >= END_ADDR)
      req_err = 2'd1;
    else if (!SPLIT_EN && req_misaligned)
      req_err = 2'd2;
  end

  logic [2:0]    acc_nbytes;
  logic          acc_cross;
  logic          acc_active;
  logic [IW-1:0] acc_idx;
  logic [31:0]   rd_word, asm_d, lane_wdata, rsp_data_d;
  logic [3:0]    lane_we;

  assign acc_nbytes = 3'd1 << size_q;
  assign acc_cross  = SPLIT_EN && (({1'b0, off_q} + acc_nbytes) > 3'd4);
  assign acc_active = (state_q == ACC0 || state_q == ACC1) && err_q == 2'd0;
  assign acc_idx    = (state_q == ACC1) ? idx_q + IW'(1) : idx_q;
  assign rd_word    = mem_q[acc_idx];

  // Lane l of the current word carries byte k of the little-endian access.
  always_comb begin
    int k;
    k          = 0;
    asm_d      = (state_q == ACC1) ? asm_q : 32'd0;
    lane_we    = 4'd0;
    lane_wdata = 32'd0;
    for (int l = 0; l < 4; l++) begin
      k = (state_q == ACC1) ? l + 4 - int'(off_q) : l - int'(off_q);
      if (acc_active && k >= 0 && k < int'(acc_nbytes)) begin
        lane_we[l]          = we_q;
        lane_wdata[l*8 +: 8] = wdata_q[k*8 +: 8];
        asm_d[k*8 +: 8]      = rd_word[l*8 +: 8];
      end
    end
  end

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] sz, input logic uns);
    case (sz)
      2'd0:    return uns ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'd1:    return uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign rsp_data_d = we_q ? 32'd0 : load_ext(asm_d, size_q, uns_q);

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (lane_we[l]) mem_q[acc_idx][l*8 +: 8] <= lane_wdata[l*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 2'd0;
      wait_cnt_q  <= 4'd0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      err_q       <= 2'd0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (dmem.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= dmem.req_we;
            uns_q       <= dmem.req_unsigned;
            size_q      <= dmem.req_size;
            off_q       <= dmem.req_addr[1:0];
            idx_q       <= IW'((dmem.req_addr - ADDR_BASE) >> 2);
            wdata_q     <= dmem.req_wdata;
            err_q       <= req_err;
            wait_cnt_q  <= 4'd0;
            state_q     <= (WAIT_CYCLES > 0) ? WAIT : ACC0;
          end
        end
        WAIT: begin
          if (wait_cnt_q == 4'(WAIT_CYCLES - 1)) state_q <= ACC0;
          else wait_cnt_q <= wait_cnt_q + 4'd1;
        end
        ACC0: begin
          if (err_q == 2'd0 && acc_cross) begin
            asm_q   <= asm_d;
            state_q <= ACC1;
          end else begin
            rsp_rdata_q <= (err_q == 2'd0) ? rsp_data_d : 32'd0;
            rsp_err_q   <= err_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        ACC1: begin
          rsp_rdata_q <= rsp_data_d;
          rsp_err_q   <= err_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP: begin
          if (dmem.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.req_ready = req_ready_q;
  assign dmem.rsp_valid = rsp_valid_q;
  assign dmem.rsp_rdata = rsp_rdata_q;
  assign dmem.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// tb/tb_rv32_dmem_responder.sv - directed self-checking bench for rv32_dmem_responder
module tb_rv32_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_w, sel;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  int          n_assert = 0;
  int          n_fail = 0;

  rv32_dmem_responder_if bus_a ();
  rv32_dmem_responder_if bus_w ();

  rv32_dmem_responder #(.WAIT_CYCLES(0)) u_dut_a (.clk(clk), .rst_n(rst_n_a), .dmem(bus_a));
  rv32_dmem_responder #(.WAIT_CYCLES(3)) u_dut_w (.clk(clk), .rst_n(rst_n_w), .dmem(bus_w));

  assign bus_a.req_valid    = req_valid & ~sel;
  assign bus_w.req_valid    = req_valid & sel;
  assign bus_a.rsp_ready    = rsp_ready & ~sel;
  assign bus_w.rsp_ready    = rsp_ready & sel;
  assign bus_a.req_we       = req_we;
  assign bus_w.req_we       = req_we;
  assign bus_a.req_size     = req_size;
  assign bus_w.req_size     = req_size;
  assign bus_a.req_unsigned = req_unsigned;
  assign bus_w.req_unsigned = req_unsigned;
  assign bus_a.req_addr     = req_addr;
  assign bus_w.req_addr     = req_addr;
  assign bus_a.req_wdata    = req_wdata;
  assign bus_w.req_wdata    = req_wdata;

  wire        obs_req_ready = sel ? bus_w.req_ready : bus_a.req_ready;
  wire        obs_rsp_valid = sel ? bus_w.rsp_valid : bus_a.rsp_valid;
  wire [31:0] obs_rsp_rdata = sel ? bus_w.rsp_rdata : bus_a.rsp_rdata;
  wire [1:0]  obs_rsp_err   = sel ? bus_w.rsp_err   : bus_a.rsp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int t;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    t = 0;
    while (!obs_req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_accept_ready"}, obs_req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!obs_rsp_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, obs_rsp_valid, 0);
    check({tag, "_ready_back"}, obs_req_ready, 1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic [1:0] exp_err, input int exp_lat);
    accept(tag, we, size, uns, addr, wdata);
    wait_rsp(tag, exp_lat);
    check({tag, "_rdata"}, obs_rsp_rdata, exp_rdata);
    check({tag, "_err"}, obs_rsp_err, {30'd0, exp_err});
    check({tag, "_req_ready_busy"}, obs_req_ready, 0);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    rst_n_a = 1'b0; rst_n_w = 1'b0;
    #12;
    check("rst_req_ready", bus_a.req_ready, 0);
    check("rst_rsp_valid", bus_a.rsp_valid, 0);
    check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    check("rst_rsp_err", bus_a.rsp_err, 0);
    @(negedge clk);
    rst_n_a = 1'b1; rst_n_w = 1'b1;
    @(posedge clk);
    #1 check("rel_req_ready", bus_a.req_ready, 1);

    // Basic store/load and extension
    txn("sw_10",  1, 2'd2, 0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,         2'd0, 1);
    txn("lw_10",  0, 2'd2, 0, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 2'd0, 1);
    txn("lb_13",  0, 2'd0, 0, 32'h8000_0013, 32'h0,         32'hFFFF_FFDE, 2'd0, 1);
    txn("lbu_13", 0, 2'd0, 1, 32'h8000_0013, 32'h0,         32'h0000_00DE, 2'd0, 1);
    txn("lh_12",  0, 2'd1, 0, 32'h8000_0012, 32'h0,         32'hFFFF_DEAD, 2'd0, 1);
    txn("lhu_10", 0, 2'd1, 1, 32'h8000_0010, 32'h0,         32'h0000_BEEF, 2'd0, 1);
    txn("lbu_11", 0, 2'd0, 1, 32'h8000_0011, 32'h0,         32'h0000_00BE, 2'd0, 1);
    txn("lwu_10", 0, 2'd2, 1, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 2'd0, 1);

    // Access faults and range boundaries
    txn("lw_below",  0, 2'd2, 0, 32'h7FFF_FFFC, 32'h0,         32'h0, 2'd1, 1);
    txn("sw_above",  1, 2'd2, 0, 32'h8000_8000, 32'h1234_5678, 32'h0, 2'd1, 1);
    txn("sw_last",   1, 2'd2, 0, 32'h8000_7FFC, 32'hA5A5_A5A5, 32'h0, 2'd0, 1);
    txn("lw_last",   0, 2'd2, 0, 32'h8000_7FFC, 32'h0, 32'hA5A5_A5A5, 2'd0, 1);
    txn("lb_last",   0, 2'd0, 0, 32'h8000_7FFF, 32'h0, 32'hFFFF_FFA5, 2'd0, 1);
    txn("lh_over",   0, 2'd1, 0, 32'h8000_7FFF, 32'h0, 32'h0,         2'd1, 1);
    txn("lw_fltmis", 0, 2'd2, 0, 32'h7FFF_FFFE, 32'h0, 32'h0,         2'd1, 1);
    txn("lw_10_kept", 0, 2'd2, 0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2'd0, 1);

    // Illegal size wins over everything
    txn("sz3_ok",  0, 2'd3, 0, 32'h8000_0010, 32'h0, 32'h0, 2'd3, 1);
    txn("sz3_flt", 1, 2'd3, 0, 32'h7FFF_0000, 32'h0, 32'h0, 2'd3, 1);

    // Response backpressure
    accept("bp", 0, 2'd2, 0, 32'h8000_0010, 32'h0);
    wait_rsp("bp", 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", obs_rsp_valid, 1);
      check("bp_rdata", obs_rsp_rdata, 32'hDEAD_BEEF);
      check("bp_req_ready", obs_req_ready, 0);
    end
    handshake("bp");

    // Misaligned store/load
    txn("sw_20", 1, 2'd2, 0, 32'h8000_0020, 32'h0, 32'h0, 2'd0, 1);
    txn("sw_24", 1, 2'd2, 0, 32'h8000_0024, 32'h0, 32'h0, 2'd0, 1);
`ifdef MISALIGNED_SPLIT_EN
    txn("sw_22",   1, 2'd2, 0, 32'h8000_0022, 32'h1122_3344, 32'h0,         2'd0, 2);
    txn("lw_20",   0, 2'd2, 0, 32'h8000_0020, 32'h0,         32'h3344_0000, 2'd0, 1);
    txn("lw_24",   0, 2'd2, 0, 32'h8000_0024, 32'h0,         32'h0000_1122, 2'd0, 1);
    txn("lw_22",   0, 2'd2, 0, 32'h8000_0022, 32'h0,         32'h1122_3344, 2'd0, 2);
    txn("lh_23",   0, 2'd1, 0, 32'h8000_0023, 32'h0,         32'h0000_2233, 2'd0, 2);
`else
    txn("sw_22",   1, 2'd2, 0, 32'h8000_0022, 32'h1122_3344, 32'h0, 2'd2, 1);
    txn("lw_20",   0, 2'd2, 0, 32'h8000_0020, 32'h0,         32'h0, 2'd0, 1);
    txn("lw_24",   0, 2'd2, 0, 32'h8000_0024, 32'h0,         32'h0, 2'd0, 1);
    txn("lw_22",   0, 2'd2, 0, 32'h8000_0022, 32'h0,         32'h0, 2'd2, 1);
    txn("lh_23",   0, 2'd1, 0, 32'h8000_0023, 32'h0,         32'h0, 2'd2, 1);
`endif

    // WAIT_CYCLES=3 instance: latency and reset during WAIT
    sel = 1'b1;
    txn("w_sw", 1, 2'd2, 0, 32'h8000_0010, 32'h1234_5678, 32'h0,         2'd0, 4);
    txn("w_lw", 0, 2'd2, 0, 32'h8000_0010, 32'h0,         32'h1234_5678, 2'd0, 4);
    accept("w_rst", 0, 2'd2, 0, 32'h8000_0010, 32'h0);
    @(posedge clk);
    #2 rst_n_w = 1'b0;
    #1;
    check("w_rst_valid", obs_rsp_valid, 0);
    check("w_rst_ready", obs_req_ready, 0);
    @(negedge clk) rst_n_w = 1'b1;
    @(posedge clk);
    #1 check("w_rel_ready", obs_req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("w_no_stale_rsp", obs_rsp_valid, 0);
    end
    txn("w_lw_after", 0, 2'd0, 1, 32'h8000_0010, 32'h0, 32'h0000_0078, 2'd0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
